// File: rtl/tdm_mux_8_1.sv
// tdm_mux_8_1: 8:1 time-division multiplexer that captures eight 1-bit channels on
//   a frame request and serialises them one slot per enabled cycle.
// Latency: slot 0 is presented on the same edge that samples start. An unstalled frame
//   is 8 consecutive valid cycles. Back-to-back frames leave no gap.
// Backpressure: en=0 stalls the frame. Select and data hold and valid drops, so each
//   slot is marked valid exactly once.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over start/en)
//   start        frame request, honoured in IDLE or on the slot-7 advance edge
//   en           advance enable while a frame is in progress (ignored in IDLE)
//   I1..I8       channel inputs; I1 -> slot 0 ... I8 -> slot 7
//   a,b,c        slot select (a = MSB); {a,b,c}=n routes D to demux output Y(n+1)
//   D            serial data bit for the current slot
//   valid        a,b,c,D carry a new slot this cycle
//   frame_start  slot 0 is valid this cycle
//   busy         frame in progress
//   done         one-cycle pulse after slot 7 when no new frame follows
//   CONTINUOUS   1: after slot 7, recapture and start a new frame without start

module tdm_mux_8_1 #(
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic I5,
    input  logic I6,
    input  logic I7,
    input  logic I8,
    output logic a,
    output logic b,
    output logic c,
    output logic D,
    output logic valid,
    output logic frame_start,
    output logic busy,
    output logic done
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_q, state_d;

    // Shadow copy of the channel inputs; sh_q[n] holds I(n+1) for the whole frame.
    logic [7:0] sh_q, sh_d;
    // Index of the slot currently shown on the outputs.
    logic [2:0] slot_q, slot_d;

    // Registered output values and their next-cycle values.
    logic [2:0] sel_q, sel_d;
    logic       dat_q, dat_d;
    logic       vld_q, vld_d;
    logic       fs_q, fs_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] in_vec;
    logic [2:0] slot_inc;
    logic       frame_req;
    logic       at_last;
    logic       capture;
    logic       finish;
    logic       advance;

    assign in_vec    = {I8, I7, I6, I5, I4, I3, I2, I1};
    assign slot_inc  = slot_q + 3'd1;
    assign frame_req = start | CONTINUOUS;

    // The slot-7 advance edge can either start the next frame or end this one.
    // A stalled slot 7 does neither, so done is deferred until en returns.
    assign at_last = (state_q == SEND) && en && (slot_q == 3'd7);
    assign capture = frame_req && ((state_q == IDLE) || at_last);
    assign finish  = at_last && !frame_req;
    assign advance = (state_q == SEND) && en && (slot_q != 3'd7);

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            slot_q  <= '0;
            sel_q   <= '0;
            dat_q   <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic: FSM state, shadow register and slot counter
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        slot_d  = slot_q;

        if (capture) begin
            state_d = SEND;
            sh_d    = in_vec;
            slot_d  = 3'd0;
        end else if (finish) begin
            state_d = IDLE;
            slot_d  = 3'd0;
        end else if (advance) begin
            slot_d  = slot_inc;
        end
    end

    //--------------------------------------------------------------------------
    // Output logic: values loaded into the output registers on this edge
    //--------------------------------------------------------------------------
    always_comb begin
        // Stall default: select and data hold, no new slot is flagged.
        sel_d  = sel_q;
        dat_d  = dat_q;
        vld_d  = 1'b0;
        fs_d   = 1'b0;
        busy_d = (state_d == SEND);
        done_d = finish;

        if (capture) begin
            // The captured I1 goes straight out, so slot 0 needs no extra cycle.
            sel_d = 3'd0;
            dat_d = I1;
            vld_d = 1'b1;
            fs_d  = 1'b1;
        end else if (advance) begin
            sel_d = slot_inc;
            dat_d = sh_q[slot_inc];
            vld_d = 1'b1;
        end else if (state_d == IDLE) begin
            sel_d = 3'd0;
            dat_d = 1'b0;
        end
    end

    assign a           = sel_q[2];
    assign b           = sel_q[1];
    assign c           = sel_q[0];
    assign D           = dat_q;
    assign valid       = vld_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Bench for tdm_mux_8_1: a one-shot instance (CONTINUOUS=0) and a free-running
// instance (CONTINUOUS=1) share all inputs. A reference model pushes every expected
// slot into a per-instance queue. A negedge monitor pops one entry per valid cycle,
// checks the per-cycle status, and checks the held select/data between slots.

module tb_tdm_mux_8_1;

    logic       clk = 1'b0;
    logic       rst, start, en;
    logic [7:0] ivec;

    logic a0, b0, c0, d0, v0, fs0, bz0, dn0;
    logic a1, b1, c1, d1, v1, fs1, bz1, dn1;

    always #5 clk = ~clk;

    tdm_mux_8_1 #(.CONTINUOUS(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .I1(ivec[0]), .I2(ivec[1]), .I3(ivec[2]), .I4(ivec[3]),
        .I5(ivec[4]), .I6(ivec[5]), .I7(ivec[6]), .I8(ivec[7]),
        .a(a0), .b(b0), .c(c0), .D(d0), .valid(v0),
        .frame_start(fs0), .busy(bz0), .done(dn0)
    );

    tdm_mux_8_1 #(.CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .I1(ivec[0]), .I2(ivec[1]), .I3(ivec[2]), .I4(ivec[3]),
        .I5(ivec[4]), .I6(ivec[5]), .I7(ivec[6]), .I8(ivec[7]),
        .a(a1), .b(b1), .c(c1), .D(d1), .valid(v1),
        .frame_start(fs1), .busy(bz1), .done(dn1)
    );

    // Reference model state (index 0 = one-shot, 1 = continuous).
    bit         act [2];
    int         pos [2];
    logic [7:0] bits[2];
    logic       ev_valid[2], ev_busy[2], ev_done[2], ev_d[2];
    logic [2:0] ev_abc[2];
    // Expected slots: {frame_start, slot[2:0], D}.
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    int   vectors     = 0;
    int   miscompares = 0;
    bit   running     = 1'b0;
    int   vcount0     = 0;
    int   vcount1     = 0;
    logic [7:0] yv    = '0;   // demux loopback image of the one-shot instance

    task automatic chk(input string nm, input int k, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h, expected %0h @%0t", nm, k, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int k, input logic [4:0] e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock edge of the spec's behaviour for one instance.
    task automatic model_edge(input int k, input bit cont);
        bit req;
        req        = start || cont;
        ev_done[k] = 1'b0;
        if (rst) begin
            act[k] = 1'b0; pos[k] = 0;
            ev_valid[k] = 1'b0; ev_busy[k] = 1'b0; ev_abc[k] = 3'd0; ev_d[k] = 1'b0;
        end else if (!act[k] || (en && pos[k] == 7)) begin
            if (req) begin
                bits[k] = ivec; pos[k] = 0; act[k] = 1'b1;
                ev_valid[k] = 1'b1; ev_busy[k] = 1'b1; ev_abc[k] = 3'd0; ev_d[k] = ivec[0];
                push_exp(k, {1'b1, 3'd0, ivec[0]});
            end else begin
                ev_done[k] = act[k];
                act[k] = 1'b0;
                ev_valid[k] = 1'b0; ev_busy[k] = 1'b0; ev_abc[k] = 3'd0; ev_d[k] = 1'b0;
            end
        end else if (en) begin
            pos[k]++;
            ev_valid[k] = 1'b1; ev_abc[k] = 3'(pos[k]); ev_d[k] = bits[k][pos[k]];
            push_exp(k, {1'b0, 3'(pos[k]), bits[k][pos[k]]});
        end else begin
            ev_valid[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_edge(0, 1'b0);
        model_edge(1, 1'b1);
        running = 1'b1;
    end

    task automatic check_out(input int k, input logic [2:0] abc, input logic d,
                             input logic v, input logic fs, input logic bz, input logic dn);
        logic [4:0] e;
        chk("valid", k, 8'(v),  8'(ev_valid[k]));
        chk("busy",  k, 8'(bz), 8'(ev_busy[k]));
        chk("done",  k, 8'(dn), 8'(ev_done[k]));
        if (v === 1'b1) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                chk("unexpected_valid", k, 8'(v), 8'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("slot{fs,abc,D}", k, 8'({fs, abc, d}), 8'(e));
            end
        end else begin
            chk("hold{fs,abc,D}", k, 8'({fs, abc, d}), 8'({1'b0, ev_abc[k], ev_d[k]}));
        end
        // Every expected slot must have appeared on the cycle it was due.
        if (k == 0) begin
            chk("sb_pending", k, 8'(q0.size()), 8'd0);
            q0.delete();
        end else begin
            chk("sb_pending", k, 8'(q1.size()), 8'd0);
            q1.delete();
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            check_out(0, {a0, b0, c0}, d0, v0, fs0, bz0, dn0);
            check_out(1, {a1, b1, c1}, d1, v1, fs1, bz1, dn1);
            if (v0 === 1'b1) begin
                vcount0 = vcount0 + 1;
                yv[{a0, b0, c0}] = d0;
            end
            if (v1 === 1'b1) vcount1 = vcount1 + 1;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int snap;

    initial begin
        // Reset held with start and all inputs high.
        rst = 1'b1; start = 1'b1; en = 1'b1; ivec = 8'hFF;
        cyc(2);
        // First edge after release must start a frame.
        rst = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(10);

        // Single frame I1..I8 = 1,0,1,1,0,0,1,0, followed by the demux loopback image.
        ivec = 8'h4D; start = 1'b1;
        cyc(1);
        start = 1'b0; ivec = 8'h00;
        cyc(10);
        chk("demux_Y", 0, yv, 8'h4D);

        // Stall for 3 cycles after slot 2.
        snap = vcount0;
        ivec = 8'h96; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(8);
        chk("stall_valid_count", 0, 8'(vcount0 - snap), 8'd8);

        // Back-to-back frames: A5, then 3C loaded during frame 1.
        ivec = 8'hA5; start = 1'b1;
        cyc(3);
        ivec = 8'h3C;
        cyc(9);
        start = 1'b0;
        cyc(8);

        // Reset at slot 4, then a fresh frame.
        ivec = 8'h5A; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; ivec = 8'hC3; start = 1'b1;
        cyc(1);
        start = 1'b0; ivec = 8'h00;
        cyc(10);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) == 0);
            en    = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 59) == 0);
            ivec  = 8'($urandom);
            cyc(1);
        end

        // Continuous instance without start: valid must stay high.
        rst = 1'b0; start = 1'b0; en = 1'b1;
        cyc(2);
        snap = vcount1;
        for (int i = 0; i < 40; i++) begin
            ivec = 8'($urandom);
            cyc(1);
        end
        chk("cont_duty", 1, 8'(vcount1 - snap), 8'd40);

        cyc(12);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
